// File: rtl/data_mem_lsu_if.sv
// Request/response channel between the memory-stage core logic and the data memory LSU.
// The core drives the master side; the memory block sits on the slave side.
interface data_mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Byte-addressed data memory with RISC-V load/store width handling.
// Provides a single-outstanding valid/ready request/response channel and a fixed number of wait states.
module data_mem_lsu #(
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 2,
    parameter     INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          rst,
    data_mem_lsu_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic          rdy;
    logic          accept;
    logic [2:0]    f3;
    logic [31:0]   addr;
    logic [AW-1:0] widx;
    logic          range_ok;
    logic          f3_ok;
    logic          mis;
    logic          err;
    logic          wr_en;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic [31:0]   rword;

    function automatic logic [31:0] load_ext(input logic [2:0] fn, input logic [31:0] w,
                                             input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*lane +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (fn)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = w;
        endcase
    endfunction

    assign f3       = bus.req_funct3;
    assign addr     = bus.req_addr;
    assign widx     = addr[AW+1:2];
    assign range_ok = (addr[31:2] < 30'(DEPTH));
    assign accept   = bus.req_valid && rdy;
    assign rword    = mem[widx];

    always_comb begin
        f3_ok = 1'b0;
        mis   = 1'b0;
        be    = 4'b0000;
        wd    = bus.req_wdata;
        case (f3)
            3'b000: begin
                f3_ok = 1'b1;
                be    = 4'b0001 << addr[1:0];
                wd    = {4{bus.req_wdata[7:0]}};
            end
            3'b001: begin
                f3_ok = 1'b1;
                mis   = addr[0];
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wd    = {2{bus.req_wdata[15:0]}};
            end
            3'b010: begin
                f3_ok = 1'b1;
                mis   = |addr[1:0];
                be    = 4'b1111;
            end
            // Unsigned loads have no store counterpart.
            3'b100, 3'b101: begin
                f3_ok = !bus.req_we;
                mis   = f3[0] & addr[0];
            end
            default: f3_ok = 1'b0;
        endcase
        err   = !f3_ok || mis || !range_ok;
        wr_en = accept && bus.req_we && !err;
    end

    // Memory array is outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && be[b]) begin
                mem[widx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    err_d   = err;
                    rdata_d = (err || bus.req_we) ? 32'd0 : load_ext(f3, rword, addr[1:0]);
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ready is masked by reset so nothing is accepted while reset is held.
    always_comb begin
        rdy           = rst && (state_q == S_IDLE);
        bus.req_ready = rdy;
        bus.rsp_valid = (state_q == S_RESP);
        bus.busy      = (state_q != S_IDLE);
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
    end
endmodule
